// File: rtl/alu_arbiter_if.sv
// Purpose: requester/response/ALU bundle shared by the two-port ALU arbiter.
// Latency: none (wires only).
// Backpressure: valid/ready on the request side and on the response side.
// Ports: req0_*/req1_* request handshake and operands, resp0_*/resp1_* response
//        handshake with shared resp_result/resp_cout, alu_* operand and result
//        lines to/from the registered add/subtract ALU.
//        slave = arbiter view, master = requesters + ALU view.
interface alu_arbiter_if #(
   parameter int DATA_BITS = 8
);
   logic                 req0_valid;
   logic                 req1_valid;
   logic                 req0_ready;
   logic                 req1_ready;
   logic [DATA_BITS-1:0] req0_a;
   logic [DATA_BITS-1:0] req1_a;
   logic [DATA_BITS-1:0] req0_b;
   logic [DATA_BITS-1:0] req1_b;
   logic                 req0_sub;
   logic                 req1_sub;

   logic                 resp0_valid;
   logic                 resp1_valid;
   logic                 resp0_ready;
   logic                 resp1_ready;
   logic [DATA_BITS-1:0] resp_result;
   logic                 resp_cout;

   logic [DATA_BITS-1:0] alu_a;
   logic [DATA_BITS-1:0] alu_b;
   logic                 alu_cin;
   logic [DATA_BITS-1:0] alu_result;
   logic                 alu_cout;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
             req0_sub, req1_sub, resp0_ready, resp1_ready,
             alu_result, alu_cout,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
             resp_result, resp_cout, alu_a, alu_b, alu_cin
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
             req0_sub, req1_sub, resp0_ready, resp1_ready,
             alu_result, alu_cout,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
             resp_result, resp_cout, alu_a, alu_b, alu_cin
   );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: round-robin share of one registered add/sub ALU between two requesters.
// Latency: accept at cycle T, response valid at T+1 (held until consumed).
// Backpressure: one-entry hold buffer; a pending held result stops new grants.
// Ports: clk, reset (sync, active-high); bus (alu_arbiter_if.slave) carries the
//        request handshakes/operands, the response handshakes with shared
//        result/carry, and the operand/carry-in lines to and result from the ALU.
//        DATA_BITS must match the interface instance and the ALU width.
module alu_arbiter #(
   parameter int DATA_BITS = 8
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);
   logic                 prio;          // preferred requester when both are valid
   logic                 inflight_v;    // an operation was issued last cycle
   logic                 inflight_tag;
   logic                 hold_v;
   logic                 hold_tag;
   logic                 hold_cout;
   logic [DATA_BITS-1:0] hold_result;

   logic                 src_v;
   logic                 src_tag;
   logic                 src_ready;
   logic                 issue_ok;
   logic                 grant0;
   logic                 grant1;

   // Response source: the hold buffer wins, otherwise the live ALU output.
   // Outputs are forced quiet while reset is high so a result in flight at
   // reset time is never presented.
   always_comb begin
      src_tag   = hold_v ? hold_tag : inflight_tag;
      src_v     = !reset && (hold_v || inflight_v);
      src_ready = src_tag ? bus.resp1_ready : bus.resp0_ready;
      // Only issue when the result landing next cycle is sure to have a home:
      // either nothing is in flight, or the in-flight result leaves this cycle.
      issue_ok  = !reset && !hold_v && (!inflight_v || src_ready);
      grant0    = issue_ok && bus.req0_valid && (!bus.req1_valid || !prio);
      grant1    = issue_ok && bus.req1_valid && (!bus.req0_valid ||  prio);
   end

   always_comb begin
      bus.req0_ready = grant0;
      bus.req1_ready = grant1;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      bus.alu_cin    = 1'b0;
      if (grant0) begin
         bus.alu_a   = bus.req0_a;
         bus.alu_b   = bus.req0_b;
         bus.alu_cin = bus.req0_sub;
      end else if (grant1) begin
         bus.alu_a   = bus.req1_a;
         bus.alu_b   = bus.req1_b;
         bus.alu_cin = bus.req1_sub;
      end
      bus.resp0_valid = src_v && !src_tag;
      bus.resp1_valid = src_v &&  src_tag;
      bus.resp_result = '0;
      bus.resp_cout   = 1'b0;
      if (src_v) begin
         bus.resp_result = hold_v ? hold_result : bus.alu_result;
         bus.resp_cout   = hold_v ? hold_cout   : bus.alu_cout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio         <= 1'b0;
         inflight_v   <= 1'b0;
         inflight_tag <= 1'b0;
         hold_v       <= 1'b0;
         hold_tag     <= 1'b0;
         hold_cout    <= 1'b0;
         hold_result  <= '0;
      end else begin
         inflight_v <= grant0 || grant1;
         if (grant0 || grant1) begin
            inflight_tag <= grant1;
            prio         <= !grant1;
         end
         // With hold_v clear, src_* refer to the in-flight result.
         if (inflight_v && !hold_v && !src_ready) begin
            hold_v      <= 1'b1;
            hold_tag    <= inflight_tag;
            hold_result <= bus.alu_result;
            hold_cout   <= bus.alu_cout;
         end else if (hold_v && src_ready) begin
            hold_v <= 1'b0;
         end
      end
   end

   // A filled hold buffer blocks issue, so it can never coexist with a new
   // in-flight operation.
   assert property (@(posedge clk) disable iff (reset) !(hold_v && inflight_v));

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_BITS(8)) bus ();

   alu_arbiter #(.DATA_BITS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stand-in for the registered ALU: no reset, starts with garbage.
   logic [7:0] alu_r = 8'hA5;
   logic       alu_c = 1'b1;
   always @(posedge clk)
      {alu_c, alu_r} <= {1'b0, bus.alu_a} + {1'b0, (bus.alu_cin ? ~bus.alu_b : bus.alu_b)}
                        + {8'd0, bus.alu_cin};
   assign bus.alu_result = alu_r;
   assign bus.alu_cout   = alu_c;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic from the operation's meaning, not from carry logic.
   function automatic logic [8:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic s);
      int unsigned ai = a;
      int unsigned bi = b;
      logic [7:0]  res;
      logic        c;
      if (s) begin
         res = 8'((ai + 256 - bi) % 256);
         c   = (ai >= bi);
      end else begin
         res = 8'((ai + bi) % 256);
         c   = (ai + bi) > 255;
      end
      return {c, res};
   endfunction

   // ---------------- scoreboard model ----------------
   typedef struct {
      bit         tag;
      logic [7:0] res;
      bit         cout;
      bit         held;   // missed its first delivery cycle
   } exp_t;

   exp_t q[$];
   bit   pref = 1'b0;     // requester that wins a tie next

   always @(negedge clk) begin
      bit         allow, g0, g1, rdy;
      logic [7:0] ea, eb;
      bit         ecin;
      exp_t       e;
      logic [8:0] r;
      if (reset) begin
         check("rst_req0_ready", bus.req0_ready, 0);
         check("rst_req1_ready", bus.req1_ready, 0);
         check("rst_resp0_valid", bus.resp0_valid, 0);
         check("rst_resp1_valid", bus.resp1_valid, 0);
         check("rst_resp_result", bus.resp_result, 0);
         check("rst_resp_cout", bus.resp_cout, 0);
         check("rst_alu_ops", {bus.alu_cin, bus.alu_a, bus.alu_b}, 0);
         q.delete();
         pref = 1'b0;
      end else begin
         rdy   = (q.size() != 0) && (q[0].tag ? bus.resp1_ready : bus.resp0_ready);
         allow = (q.size() == 0) || (!q[0].held && rdy);
         g0 = allow && bus.req0_valid && (!bus.req1_valid || pref == 1'b0);
         g1 = allow && bus.req1_valid && (!bus.req0_valid || pref == 1'b1);
         check("req0_ready", bus.req0_ready, g0);
         check("req1_ready", bus.req1_ready, g1);
         ea = 8'd0; eb = 8'd0; ecin = 1'b0;
         if (g0) begin ea = bus.req0_a; eb = bus.req0_b; ecin = bus.req0_sub; end
         if (g1) begin ea = bus.req1_a; eb = bus.req1_b; ecin = bus.req1_sub; end
         check("alu_ops", {bus.alu_cin, bus.alu_a, bus.alu_b}, {ecin, ea, eb});
         if (q.size() != 0) begin
            check("resp0_valid", bus.resp0_valid, !q[0].tag);
            check("resp1_valid", bus.resp1_valid,  q[0].tag);
            check("resp_result", bus.resp_result, q[0].res);
            check("resp_cout", bus.resp_cout, q[0].cout);
            if (rdy) void'(q.pop_front());
            else begin
               e = q[0]; e.held = 1'b1; q[0] = e;
            end
         end else begin
            check("idle_resp_valid", {bus.resp1_valid, bus.resp0_valid}, 0);
            check("idle_resp_data", {bus.resp_cout, bus.resp_result}, 0);
         end
         if (g0 || g1) begin
            r = g1 ? ref_op(bus.req1_a, bus.req1_b, bus.req1_sub)
                   : ref_op(bus.req0_a, bus.req0_b, bus.req0_sub);
            e.tag = g1; e.res = r[7:0]; e.cout = r[8]; e.held = 1'b0;
            q.push_back(e);
            pref = !g1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input bit s0,
                        input bit v1, input logic [7:0] a1, input logic [7:0] b1, input bit s1);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sub = s0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = s1;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      bit         sub;
      logic [7:0] res;
      bit         cout;
   } vec_t;

   vec_t vecs [3] = '{
      '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1},
      '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1}
   };

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      repeat (2) nxt();

      // req0 add, same-cycle ready, response one cycle later
      reset = 1'b0;
      drive(1, 8'h05, 8'h03, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_req0_ready", bus.req0_ready, 1);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t1_resp0_valid", bus.resp0_valid, 1);
      check("t1_result", bus.resp_result, 8'h08);
      check("t1_cout", bus.resp_cout, 0);

      // req1 subtract / overflow vectors
      foreach (vecs[i]) begin
         nxt();
         drive(0, 0, 0, 0, 1, vecs[i].a, vecs[i].b, vecs[i].sub);
         @(negedge clk);
         check("t2_req1_ready", bus.req1_ready, 1);
         nxt();
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         check("t2_resp1_valid", bus.resp1_valid, 1);
         check("t2_result", bus.resp_result, vecs[i].res);
         check("t2_cout", bus.resp_cout, vecs[i].cout);
      end

      // both valid for 6 cycles: grants alternate starting with requester 0
      for (int i = 0; i < 6; i++) begin
         nxt();
         drive(1, 8'(i), 8'h01, 0, 1, 8'(8'h40 + i), 8'h02, 1);
         @(negedge clk);
         check("t3_req0_ready", bus.req0_ready, (i % 2) == 0);
         check("t3_req1_ready", bus.req1_ready, (i % 2) == 1);
      end
      nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // req0 result held for 3 cycles, req1 blocked until the hold drains
      nxt();
      drive(1, 8'h10, 8'h20, 0, 0, 0, 0, 0);
      bus.resp0_ready = 1'b0;
      @(negedge clk);
      check("t4_req0_ready", bus.req0_ready, 1);
      for (int k = 0; k < 3; k++) begin
         nxt();
         drive(0, 0, 0, 0, 1, 8'h07, 8'h02, 1);
         @(negedge clk);
         check("t4_hold_valid", bus.resp0_valid, 1);
         check("t4_hold_result", bus.resp_result, 8'h30);
         check("t4_blocked", bus.req1_ready, 0);
      end
      nxt();
      bus.resp0_ready = 1'b1;
      @(negedge clk);
      check("t4_drain_valid", bus.resp0_valid, 1);
      check("t4_drain_blocked", bus.req1_ready, 0);
      nxt();
      @(negedge clk);
      check("t4_resume", bus.req1_ready, 1);
      check("t4_no_resp0", bus.resp0_valid, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_resp1_result", bus.resp_result, 8'h05);
      check("t4_resp1_cout", bus.resp_cout, 1);

      // reset the cycle after an accept
      nxt();
      drive(1, 8'h11, 8'h22, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t5_req0_ready", bus.req0_ready, 1);
      nxt();
      reset = 1'b1;
      drive(1, 8'h01, 8'h01, 0, 1, 8'h09, 8'h01, 0);
      @(negedge clk);
      check("t5_rst_resp0", bus.resp0_valid, 0);
      check("t5_rst_result", bus.resp_result, 0);
      check("t5_rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
      nxt();
      reset = 1'b0;
      @(negedge clk);
      check("t5_first_grant", bus.req0_ready, 1);
      check("t5_no_stale", {bus.resp1_valid, bus.resp0_valid}, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t5_resp0_result", bus.resp_result, 8'h02);

      // random traffic, checked by the scoreboard every cycle
      for (int i = 0; i < 10000; i++) begin
         nxt();
         drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         bus.resp0_ready = ($urandom_range(0, 9) < 7);
         bus.resp1_ready = ($urandom_range(0, 9) < 7);
      end
      nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      repeat (3) nxt();
      @(negedge clk);
      check("end_queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
